// File: rtl/key_serial_encoder_if.sv
// Bus bundle between the pushbutton front end and the serial bit encoder.
// Inputs to the encoder : start, key1, key2 (raw pushbuttons, pressed = high)
// Outputs from encoder  : sEEG, sEEG_valid, bit_count, busy, frame_done, conflict
// master = stimulus / consumer side, slave = encoder side.
interface key_serial_encoder_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned BC_W = $clog2(WIDTH + 1);

    logic            start;
    logic            key1;
    logic            key2;
    logic            sEEG;
    logic            sEEG_valid;
    logic [BC_W-1:0] bit_count;
    logic            busy;
    logic            frame_done;
    logic            conflict;

    modport master (
        output start, key1, key2,
        input  sEEG, sEEG_valid, bit_count, busy, frame_done, conflict
    );

    modport slave (
        input  start, key1, key2,
        output sEEG, sEEG_valid, bit_count, busy, frame_done, conflict
    );
endinterface

// File: rtl/key_serial_encoder.sv
// Turns three raw pushbuttons into a serial bit stream of WIDTH-bit frames.
// start arms a frame, key1 enters a 1, key2 enters a 0. Each button is
// synchronized (two flops), debounced (DEB_CYCLES stable samples) and
// edge-detected into a one-cycle press event that drives a small FSM.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - slave modport: start/key1/key2 in; sEEG, sEEG_valid, bit_count,
//          busy, frame_done, conflict out (all registered)
module key_serial_encoder #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 rst,
    key_serial_encoder_if.slave  bus
);
    localparam int unsigned BC_W    = $clog2(WIDTH + 1);
    localparam int unsigned DEB_W   = $clog2(DEB_CYCLES);
    localparam int unsigned N_IN    = 3;
    localparam int unsigned I_START = 0;
    localparam int unsigned I_KEY1  = 1;
    localparam int unsigned I_KEY2  = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    logic [N_IN-1:0]  raw;
    logic [N_IN-1:0]  sync1_q;
    logic [N_IN-1:0]  sync2_q;
    logic [N_IN-1:0]  deb_q;
    logic [N_IN-1:0]  deb_d;
    logic [N_IN-1:0]  deb_dly_q;
    logic [N_IN-1:0]  press_q;
    logic [DEB_W-1:0] cnt_q [N_IN];
    logic [DEB_W-1:0] cnt_d [N_IN];

    logic start_ev;
    logic key1_ev;
    logic key2_ev;

    state_t          state_q;
    state_t          state_d;
    logic            seeg_q,       seeg_d;
    logic            valid_q,      valid_d;
    logic [BC_W-1:0] bcnt_q,       bcnt_d;
    logic            busy_q,       busy_d;
    logic            frame_done_q, frame_done_d;
    logic            conflict_q,   conflict_d;

    assign raw = {bus.key2, bus.key1, bus.start};

    // Debounce: count consecutive samples that disagree with the accepted level.
    always_comb begin
        for (int i = 0; i < int'(N_IN); i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    // Synchronizers, debounced levels and registered rising-edge press events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            press_q   <= '0;
            for (int i = 0; i < int'(N_IN); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            press_q   <= deb_q & ~deb_dly_q;
            for (int i = 0; i < int'(N_IN); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign start_ev = press_q[I_START];
    assign key1_ev  = press_q[I_KEY1];
    assign key2_ev  = press_q[I_KEY2];

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a restart or a two-key conflict never completes a frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ev) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!start_ev && (key1_ev ^ key2_ev) &&
                    (bcnt_q == BC_W'(WIDTH - 1))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output logic (next values of the output registers).
    // frame_done is the registered image of DONE, so it trails the final
    // strobe by one cycle and can never overlap sEEG_valid.
    always_comb begin
        seeg_d       = seeg_q;
        valid_d      = 1'b0;
        conflict_d   = 1'b0;
        bcnt_d       = bcnt_q;
        frame_done_d = (state_q == S_DONE);
        busy_d       = (state_d == S_ARMED);
        case (state_q)
            S_IDLE: begin
                bcnt_d = '0;
            end
            S_ARMED: begin
                if (start_ev) begin
                    bcnt_d = '0;
                end else if (key1_ev && key2_ev) begin
                    conflict_d = 1'b1;
                end else if (key1_ev || key2_ev) begin
                    seeg_d  = key1_ev;
                    valid_d = 1'b1;
                    bcnt_d  = bcnt_q + BC_W'(1);
                end
            end
            S_DONE: begin
                bcnt_d = '0;
            end
            default: begin
                bcnt_d = '0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seeg_q       <= 1'b0;
            valid_q      <= 1'b0;
            bcnt_q       <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            conflict_q   <= 1'b0;
        end else begin
            seeg_q       <= seeg_d;
            valid_q      <= valid_d;
            bcnt_q       <= bcnt_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            conflict_q   <= conflict_d;
        end
    end

    assign bus.sEEG       = seeg_q;
    assign bus.sEEG_valid = valid_q;
    assign bus.bit_count  = bcnt_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.conflict   = conflict_q;
endmodule

// File: tb/tb_key_serial_encoder.sv
// Directed bench for key_serial_encoder with a scoreboard of expected bits.
module tb_key_serial_encoder;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEB   = 4;
    localparam int          LAT   = DEB + 4;   // negedge samples from raise to strobe

    typedef struct packed {
        logic       b;
        logic [2:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    key_serial_encoder_if #(.WIDTH(WIDTH)) bus ();

    key_serial_encoder #(
        .WIDTH      (WIDTH),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   checks      = 0;
    int   failures    = 0;
    int   cyc_n       = 0;
    int   last_strobe = -100;
    int   strobes     = 0;
    int   frames      = 0;
    int   conflicts   = 0;
    int   model_cnt   = 0;
    logic ev_now      = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock, then observe outputs on the falling edge and feed the scoreboard.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        cyc_n++;
        ev_now = bus.sEEG_valid | bus.conflict;
        if (bus.sEEG_valid === 1'b1) begin
            strobes++;
            last_strobe = cyc_n;
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 32'(bus.sEEG_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sEEG", 32'(bus.sEEG), 32'(e.b));
                chk("bit_count_at_strobe", 32'(bus.bit_count), 32'(e.cnt));
            end
        end
        if (bus.conflict === 1'b1) conflicts++;
        if (bus.frame_done === 1'b1) begin
            frames++;
            chk("frame_done_delay", 32'(cyc_n - last_strobe), 32'd1);
            chk("frame_done_excl", 32'(bus.sEEG_valid), 32'd0);
        end
    endtask

    // Raise the given buttons for 6 cycles, observe 20 cycles, report first event.
    task automatic press_evt(input logic s, input logic k1, input logic k2, output int lat);
        lat = -1;
        bus.start = s;
        bus.key1  = k1;
        bus.key2  = k2;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (lat < 0 && ev_now === 1'b1) lat = i;
            if (i == 6) begin
                bus.start = 1'b0;
                bus.key1  = 1'b0;
                bus.key2  = 1'b0;
            end
        end
    endtask

    task automatic bit_press(input logic k1);
        exp_t e;
        int   lat;
        model_cnt++;
        e.b   = k1;
        e.cnt = 3'(model_cnt);
        exp_q.push_back(e);
        press_evt(1'b0, k1, ~k1, lat);
        chk(k1 ? "latency_key1" : "latency_key2", 32'(lat), 32'(LAT));
        if (model_cnt == int'(WIDTH)) model_cnt = 0;
    endtask

    task automatic start_press();
        int lat;
        press_evt(1'b1, 1'b0, 1'b0, lat);
        model_cnt = 0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("bit_count_after_start", 32'(bus.bit_count), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_sEEG"},       32'(bus.sEEG),       32'd0);
        chk({tag, "_sEEG_valid"}, 32'(bus.sEEG_valid), 32'd0);
        chk({tag, "_bit_count"},  32'(bus.bit_count),  32'd0);
        chk({tag, "_busy"},       32'(bus.busy),       32'd0);
        chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
        chk({tag, "_conflict"},   32'(bus.conflict),   32'd0);
    endtask

    initial begin
        int   lat;
        int   s0;
        int   c0;
        int   f0;
        exp_t e;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.key1  = 1'b0;
        bus.key2  = 1'b0;
        repeat (3) cyc();
        check_all_zero("reset");
        rst = 1'b0;
        cyc();

        // Key presses in IDLE are ignored.
        s0 = strobes;
        press_evt(1'b0, 1'b1, 1'b0, lat);
        press_evt(1'b0, 1'b0, 1'b1, lat);
        chk("idle_no_strobe", 32'(strobes - s0), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Clean frame 1,0,1,1.
        start_press();
        s0 = strobes;
        bit_press(1'b1);
        bit_press(1'b0);
        bit_press(1'b1);
        chk("busy_mid_frame", 32'(bus.busy), 32'd1);
        bit_press(1'b1);
        chk("frames_after_first", 32'(frames), 32'd1);
        chk("strobes_first_frame", 32'(strobes - s0), 32'd4);
        chk("busy_after_frame", 32'(bus.busy), 32'd0);
        chk("bit_count_after_frame", 32'(bus.bit_count), 32'd0);

        // Bouncing key1: high 2, low 1, then high; one strobe timed from last rise.
        start_press();
        model_cnt++;
        e.b   = 1'b1;
        e.cnt = 3'(model_cnt);
        exp_q.push_back(e);
        s0 = strobes;
        bus.key1 = 1'b1;
        cyc();
        cyc();
        bus.key1 = 1'b0;
        cyc();
        press_evt(1'b0, 1'b1, 1'b0, lat);
        chk("latency_bounce", 32'(lat), 32'(LAT));
        chk("bounce_one_strobe", 32'(strobes - s0), 32'd1);

        // Simultaneous key1/key2 press.
        c0 = conflicts;
        s0 = strobes;
        press_evt(1'b0, 1'b1, 1'b1, lat);
        chk("latency_conflict", 32'(lat), 32'(LAT));
        chk("conflict_pulses", 32'(conflicts - c0), 32'd1);
        chk("conflict_no_strobe", 32'(strobes - s0), 32'd0);
        chk("conflict_bit_count", 32'(bus.bit_count), 32'(model_cnt));

        // Two bits in, then restart; a full frame follows.
        bit_press(1'b0);
        chk("bit_count_two", 32'(bus.bit_count), 32'd2);
        start_press();
        f0 = frames;
        bit_press(1'b0);
        bit_press(1'b1);
        bit_press(1'b0);
        bit_press(1'b0);
        chk("frame_after_restart", 32'(frames - f0), 32'd1);

        // Start and key pressed together: restart wins.
        start_press();
        bit_press(1'b1);
        s0 = strobes;
        press_evt(1'b1, 1'b1, 1'b0, lat);
        model_cnt = 0;
        chk("restart_key_no_strobe", 32'(strobes - s0), 32'd0);
        chk("restart_key_bit_count", 32'(bus.bit_count), 32'd0);
        chk("restart_key_busy", 32'(bus.busy), 32'd1);

        // Three bits, then asynchronous reset mid-cycle with key1 held.
        bit_press(1'b1);
        bit_press(1'b0);
        bit_press(1'b1);
        chk("bit_count_three", 32'(bus.bit_count), 32'd3);
        f0 = frames;
        s0 = strobes;
        @(posedge clk);
        #2;
        bus.key1 = 1'b1;
        rst      = 1'b1;
        #1;
        check_all_zero("async_reset");
        repeat (3) cyc();
        rst = 1'b0;
        repeat (12) cyc();
        bus.key1 = 1'b0;
        repeat (10) cyc();
        model_cnt = 0;
        press_evt(1'b0, 1'b0, 1'b1, lat);
        press_evt(1'b0, 1'b1, 1'b0, lat);
        chk("post_reset_no_strobe", 32'(strobes - s0), 32'd0);
        chk("post_reset_no_frame", 32'(frames - f0), 32'd0);
        chk("post_reset_busy", 32'(bus.busy), 32'd0);
        chk("post_reset_bit_count", 32'(bus.bit_count), 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
